// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: access size encoding and the queued entry format.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } mem_size_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_sb_lane_steer.sv
// Converts a byte address offset, access size and LSB-justified data into byte enables and
// replicated lane data for a word-wide memory.
module sb_lane_steer
    import store_buffer_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    always_comb begin
        be    = 4'b1111;
        wdata = data;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            SZ_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order posted-write queue with lane steering and a load hazard check.
// Define STORE_FWD_CHECK_EN for a per-entry address/byte-overlap hazard; otherwise any pending store stalls loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write,
    input  logic [AW-1:0]              write_address,
    input  logic [31:0]                DATA_out,
    input  logic [1:0]                 size,
    output logic                       full,
    input  logic                       read,
    input  logic [AW-1:0]              read_address,
    output logic                       ld_hazard,
    output logic                       mem_req,
    output logic [AW-1:0]              mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, ovf_q, ovf_d;
    sb_entry_t     ent_q [DEPTH];
    sb_entry_t     ent_d [DEPTH];
    sb_entry_t     head;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic          enq, deq;

    sb_lane_steer u_st_steer (
        .addr_lo (write_address[1:0]),
        .size    (mem_size_t'(size)),
        .data    (DATA_out),
        .be      (st_be),
        .wdata   (st_wdata)
    );

    always_comb begin
        // full is the registered flag, so a same-cycle dequeue never makes room for this write
        enq      = write && !full_q;
        deq      = (count_q != '0) && mem_ack;
        ent_d    = ent_q;
        if (enq) begin
            ent_d[wr_ptr_q] = '{waddr: 30'(write_address[AW-1:2]), be: st_be, wdata: st_wdata};
        end
        wr_ptr_d = wr_ptr_q + PW'(enq);
        rd_ptr_d = rd_ptr_q + PW'(deq);
        count_d  = count_q + CW'(enq) - CW'(deq);
        full_d   = (count_d == CW'(DEPTH));
        ovf_d    = ovf_q | (write & full_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    // Outputs are zeroed while empty so stale drained entries never appear on the bus
    assign head      = ent_q[rd_ptr_q];
    assign mem_req   = (count_q != '0);
    assign mem_addr  = mem_req ? AW'({head.waddr, 2'b00}) : '0;
    assign mem_wdata = mem_req ? head.wdata : '0;
    assign mem_be    = mem_req ? head.be : '0;
    assign count     = count_q;
    assign full      = full_q;
    assign ovf_err   = ovf_q;

`ifdef STORE_FWD_CHECK_EN
    logic [3:0]    ld_be;
    logic [31:0]   ld_wdata_unused;
    logic [PW-1:0] off;

    sb_lane_steer u_ld_steer (
        .addr_lo (read_address[1:0]),
        .size    (mem_size_t'(size)),
        .data    (32'h0),
        .be      (ld_be),
        .wdata   (ld_wdata_unused)
    );

    always_comb begin
        ld_hazard = 1'b0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (read && (CW'(off) < count_q) &&
                (ent_q[i].waddr == 30'(read_address[AW-1:2])) &&
                ((ent_q[i].be & ld_be) != 4'b0000)) begin
                ld_hazard = 1'b1;
            end
        end
    end
`else
    logic ld_unused;
    assign ld_unused = ^read_address;
    assign ld_hazard = read && (count_q != '0);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus directed literal checks.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        reset, write, read, mem_ack;
    logic [31:0] write_address, read_address, DATA_out;
    logic [1:0]  size;
    logic        full, ld_hazard, mem_req, ovf_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .write         (write),
        .write_address (write_address),
        .DATA_out      (DATA_out),
        .size          (size),
        .full          (full),
        .read          (read),
        .read_address  (read_address),
        .ld_hazard     (ld_hazard),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .count         (count),
        .ovf_err       (ovf_err)
    );

    always #5 clk = ~clk;

    int        errors = 0;
    int        checks = 0;
    bit        checking = 0;
    sb_entry_t q[$];
    bit        m_ovf = 0;

    function automatic sb_entry_t mk(logic [31:0] a, logic [1:0] sz, logic [31:0] d);
        sb_entry_t e;
        e.waddr = a[31:2];
        case (sz)
            2'b00: begin
                e.be    = 4'(1 << a[1:0]);
                e.wdata = {24'h0, d[7:0]} * 32'h0101_0101;
            end
            2'b01: begin
                e.be    = a[1] ? 4'hC : 4'h3;
                e.wdata = {16'h0, d[15:0]} * 32'h0001_0001;
            end
            default: begin
                e.be    = 4'hF;
                e.wdata = d;
            end
        endcase
        return e;
    endfunction

    function automatic bit m_hazard(bit rd, logic [31:0] ra, logic [1:0] sz);
`ifdef STORE_FWD_CHECK_EN
        sb_entry_t l;
        l = mk(ra, sz, 32'h0);
        foreach (q[i]) begin
            if (rd && q[i].waddr == ra[31:2] && (q[i].be & l.be) != 4'h0) return 1'b1;
        end
        return 1'b0;
`else
        return rd && (q.size() != 0);
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance the model, land on the next negedge.
    task automatic cyc(bit r, bit w, logic [31:0] wa, logic [31:0] d, logic [1:0] sz,
                       bit rd, logic [31:0] ra, bit ack);
        bit        m_full;
        bit        m_req;
        sb_entry_t h;
        reset = r; write = w; write_address = wa; DATA_out = d; size = sz;
        read = rd; read_address = ra; mem_ack = ack;
        #1;
        if (checking) begin
            m_req = (q.size() != 0);
            h     = m_req ? q[0] : '0;
            chk("count",     32'(count),     32'(q.size()));
            chk("full",      32'(full),      32'(q.size() == DEPTH));
            chk("mem_req",   32'(mem_req),   32'(m_req));
            chk("mem_addr",  mem_addr,       {h.waddr, 2'b00});
            chk("mem_be",    32'(mem_be),    32'(h.be));
            chk("mem_wdata", mem_wdata,      h.wdata);
            chk("ovf_err",   32'(ovf_err),   32'(m_ovf));
            chk("ld_hazard", 32'(ld_hazard), 32'(m_hazard(rd, ra, sz)));
        end
        if (r) begin
            q.delete();
            m_ovf = 0;
        end else begin
            m_full = (q.size() == DEPTH);
            if (w && m_full) m_ovf = 1;
            if (ack && q.size() != 0) void'(q.pop_front());
            if (w && !m_full) q.push_back(mk(wa, sz, d));
        end
        @(posedge clk);
        @(negedge clk);
        checking = 1;
    endtask

    task automatic rst();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic idle(bit ack);
        cyc(0, 0, 0, 0, 0, 0, 0, ack);
    endtask
    task automatic wr(logic [31:0] a, logic [1:0] sz, logic [31:0] d, bit ack);
        cyc(0, 1, a, d, sz, 0, 0, ack);
    endtask

    initial begin
        @(negedge clk);
        rst();
        chk("rst_count", 32'(count), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);

        // byte store, held until ack
        wr(32'h1003, 2'b00, 32'hAB, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req", 32'(mem_req), 1);
            chk("t1_addr", mem_addr, 32'h1000);
            chk("t1_be", 32'(mem_be), 32'h8);
            chk("t1_wdata", mem_wdata, 32'hABAB_ABAB);
            idle(i == 2);
        end
        chk("t1_req_done", 32'(mem_req), 0);

        // fill, overflow, drain
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), 2'b10, 32'hC0DE_0000 + 32'(i), 0);
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 4);
        wr(32'h200, 2'b10, 32'hDEAD_BEEF, 0);
        chk("t2_ovf", 32'(ovf_err), 1);
        chk("t2_count_hold", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", mem_wdata, 32'hC0DE_0000 + 32'(i));
            idle(1);
        end
        chk("t2_drained", 32'(count), 0);

        // halfword steering
        rst();
        wr(32'h2002, 2'b01, 32'h1234, 0);
        chk("t3_be_hi", 32'(mem_be), 32'hC);
        chk("t3_wdata", mem_wdata, 32'h1234_1234);
        idle(1);
        wr(32'h2000, 2'b01, 32'h1234, 0);
        chk("t3_be_lo", 32'(mem_be), 32'h3);
        idle(1);

        // full with same-cycle dequeue: write still dropped
        rst();
        for (int i = 0; i < 4; i++) wr(32'h400 + 32'(4 * i), 2'b10, 32'(i), 0);
        wr(32'h500, 2'b10, 32'h5, 1);
        chk("t4_count", 32'(count), 3);
        chk("t4_ovf", 32'(ovf_err), 1);
        for (int i = 0; i < 3; i++) idle(1);

        // load hazard
        rst();
        wr(32'h3000, 2'b00, 32'h55, 0);
        read = 1; read_address = 32'h3004; size = 2'b10; write = 0; mem_ack = 0;
        #1;
`ifdef STORE_FWD_CHECK_EN
        chk("t5_word_other", 32'(ld_hazard), 0);
`else
        chk("t5_word_other", 32'(ld_hazard), 1);
`endif
        cyc(0, 0, 0, 0, 2'b10, 1, 32'h3004, 0);
        read = 1; read_address = 32'h3000; size = 2'b00;
        #1;
        chk("t5_byte_same", 32'(ld_hazard), 1);
        cyc(0, 0, 0, 0, 2'b00, 1, 32'h3000, 0);

        // reset mid-drain
        rst();
        for (int i = 0; i < 3; i++) wr(32'h600 + 32'(4 * i), 2'b10, 32'(i), 0);
        chk("t6_pre_req", 32'(mem_req), 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_req", 32'(mem_req), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_ovf", 32'(ovf_err), 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 59) == 0,
                $urandom_range(0, 2) != 0,
                32'h3000 + 32'($urandom_range(0, 15)),
                $urandom,
                2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1,
                32'h3000 + 32'($urandom_range(0, 15)),
                $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
